multiword_add_ctrl: RTL and testbench

- Sequencer that performs WORDS*N-bit add/subtract by time-multiplexing one N-bit ripple_adder instance, one word per cycle, LSW first.
- Carry is registered between words.
- Sits between a requester (valid/ready operand channel) and a consumer (valid/ready result channel).
- One operation in flight at a time.

---
 rtl/multiword_add_ctrl_pkg.sv | 17 +
 rtl/ripple_adder.sv | 23 ++
 rtl/multiword_add_ctrl.sv | 110 +++++++++++
 tb/tb_multiword_add_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_ctrl_pkg.sv
// multiword_add_ctrl_pkg: shared state encoding and index-width helper for the multiword adder.
package multiword_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// ripple_adder: N-bit ripple-carry adder shared by the multiword sequencer.
module ripple_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o
);

    logic [N:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[N];

endmodule

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: WORDS*N-bit add/subtract, one N-bit word per cycle LSW first,
// carry registered between words, valid/ready on both sides, one operation in flight.
module multiword_add_ctrl
    import multiword_add_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               CLK_I,
    input  logic               RSTN_I,
    input  logic [N*WORDS-1:0] A_I,
    input  logic [N*WORDS-1:0] B_I,
    input  logic               CARRY_I,
    input  logic               SUB_I,
    input  logic               IN_VALID_I,
    output logic               IN_READY_O,
    output logic [N*WORDS-1:0] SUM_O,
    output logic               CARRY_OUT_O,
    output logic               OVF_O,
    output logic               RES_VALID_O,
    input  logic               RES_READY_I,
    output logic               BUSY_O
);

    localparam int W  = N * WORDS;
    localparam int IW = clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cy_q, cy_d, co_q, co_d, ovf_q, ovf_d;
    logic [N-1:0]  a_w, b_w, s;
    logic          c, last;

    assign a_w  = a_q[idx_q*N +: N];
    assign b_w  = b_q[idx_q*N +: N];
    assign last = idx_q == LAST;

    ripple_adder #(.N(N)) u_add (
        .a_i (a_w),
        .b_i (b_w),
        .c_i (cy_q),
        .s_o (s),
        .c_o (c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: if (IN_VALID_I) begin
                state_d = ST_ADD;
                a_d     = A_I;
                b_d     = SUB_I ? ~B_I : B_I;
                cy_d    = SUB_I ? 1'b1 : CARRY_I;
                idx_d   = '0;
            end
            ST_ADD: begin
                sum_d[idx_q*N +: N] = s;
                cy_d = c;
                if (last) begin
                    state_d = ST_DONE;
                    co_d    = c;
                    ovf_d   = (a_q[W-1] ~^ b_q[W-1]) & (s[N-1] ^ a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = RES_READY_I ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign IN_READY_O  = state_q == ST_IDLE;
    assign RES_VALID_O = state_q == ST_DONE;
    assign BUSY_O      = state_q == ST_ADD || state_q == ST_DONE;
    assign SUM_O       = sum_q;
    assign CARRY_OUT_O = co_q;
    assign OVF_O       = ovf_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb_multiword_add_ctrl: directed vectors with a result scoreboard popped by a handshake monitor.
module tb_multiword_add_ctrl;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         CLK_I = 1'b0;
    logic         RSTN_I = 1'b0;
    logic [W-1:0] A_I = '0;
    logic [W-1:0] B_I = '0;
    logic         CARRY_I = 1'b0;
    logic         SUB_I = 1'b0;
    logic         IN_VALID_I = 1'b0;
    logic         RES_READY_I = 1'b1;
    logic         IN_READY_O, CARRY_OUT_O, OVF_O, RES_VALID_O, BUSY_O;
    logic [W-1:0] SUM_O;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    multiword_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .CLK_I       (CLK_I),
        .RSTN_I      (RSTN_I),
        .A_I         (A_I),
        .B_I         (B_I),
        .CARRY_I     (CARRY_I),
        .SUB_I       (SUB_I),
        .IN_VALID_I  (IN_VALID_I),
        .IN_READY_O  (IN_READY_O),
        .SUM_O       (SUM_O),
        .CARRY_OUT_O (CARRY_OUT_O),
        .OVF_O       (OVF_O),
        .RES_VALID_O (RES_VALID_O),
        .RES_READY_I (RES_READY_I),
        .BUSY_O      (BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // result words are packed as {sum, carry_out, ovf}
    always @(negedge CLK_I) begin
        if (RSTN_I && RES_VALID_O && RES_READY_I) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0h with no entry expected", SUM_O);
            end else begin
                e = sb.pop_front();
                chk("result", {14'd0, SUM_O, CARRY_OUT_O, OVF_O}, {14'd0, e.sum, e.co, e.ovf});
            end
        end
    end

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(posedge CLK_I); #1;
            k++;
        end
        chk({nm, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] es, input logic eco, input logic eovf);
        int k;
        A_I = a; B_I = b; CARRY_I = cin; SUB_I = sub; IN_VALID_I = 1'b1;
        sb.push_back('{es, eco, eovf});
        k = 0;
        while (!IN_READY_O && k < 20) begin
            @(posedge CLK_I); #1;
            k++;
        end
        if (!IN_READY_O) begin
            chk({nm, "_accept_timeout"}, 0, 1);
            IN_VALID_I = 1'b0;
            sb.delete();
            return;
        end
        @(posedge CLK_I); #1;
        IN_VALID_I = 1'b0;
        A_I = 16'($urandom); B_I = 16'($urandom); CARRY_I = ~cin; SUB_I = ~sub;
        repeat (WORDS - 1) @(posedge CLK_I);
        #1;
        chk({nm, "_valid_early"}, RES_VALID_O, 0);
        @(posedge CLK_I); #1;
        chk({nm, "_valid_at_latency"}, RES_VALID_O, 1);
        drain(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        #2;
        chk("rst_in_ready", IN_READY_O, 1);
        chk("rst_res_valid", RES_VALID_O, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_sum", SUM_O, 0);
        chk("rst_carry", CARRY_OUT_O, 0);
        chk("rst_ovf", OVF_O, 0);
        #11 RSTN_I = 1'b1;
        @(posedge CLK_I); #1;

        do_op("add_00ff_1",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ffff_ci", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_5_7",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_7_5",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

        // backpressure: first result held while a second request waits
        RES_READY_I = 1'b0;
        sb.push_back('{16'h2143, 1'b0, 1'b0});
        A_I = 16'h1234; B_I = 16'h0F0F; CARRY_I = 1'b0; SUB_I = 1'b0; IN_VALID_I = 1'b1;
        @(posedge CLK_I); #1;
        A_I = 16'h0007; B_I = 16'h0005; SUB_I = 1'b1;
        k = 0;
        while (!RES_VALID_O && k < 20) begin
            @(posedge CLK_I); #1;
            k++;
        end
        chk("bp_valid_reached", RES_VALID_O, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK_I); #1;
            chk("bp_sum", SUM_O, 16'h2143);
            chk("bp_carry", CARRY_OUT_O, 0);
            chk("bp_ovf", OVF_O, 0);
            chk("bp_in_ready", IN_READY_O, 0);
            chk("bp_res_valid", RES_VALID_O, 1);
        end
        RES_READY_I = 1'b1;
        sb.push_back('{16'h0002, 1'b1, 1'b0});
        @(posedge CLK_I); #1;
        chk("bp_idle_ready", IN_READY_O, 1);
        chk("bp_idle_valid", RES_VALID_O, 0);
        @(posedge CLK_I); #1;
        chk("bp_pending_accepted", BUSY_O, 1);
        IN_VALID_I = 1'b0;
        drain("bp_second");

        // asynchronous reset while idx==2 in ADD
        A_I = 16'h5555; B_I = 16'h3333; CARRY_I = 1'b0; SUB_I = 1'b0; IN_VALID_I = 1'b1;
        @(posedge CLK_I); #1;
        IN_VALID_I = 1'b0;
        @(posedge CLK_I);
        @(posedge CLK_I); #3;
        chk("mid_busy_before", BUSY_O, 1);
        RSTN_I = 1'b0;
        #1;
        chk("mid_rst_sum", SUM_O, 0);
        chk("mid_rst_carry", CARRY_OUT_O, 0);
        chk("mid_rst_ovf", OVF_O, 0);
        chk("mid_rst_busy", BUSY_O, 0);
        chk("mid_rst_in_ready", IN_READY_O, 1);
        chk("mid_rst_res_valid", RES_VALID_O, 0);
        @(posedge CLK_I); #3;
        RSTN_I = 1'b1;
        do_op("post_rst_add", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
